// File: rtl/axi_pkg.sv
// Shared AXI encodings and the write-initiator state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_err_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_master_write_if.sv
// AXI write address, data and response channels between one initiator and one target.
interface axi_master_write_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 12
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [ID_W-1:0]   awid;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic [ID_W-1:0]     wid;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wid,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wid,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface

// File: rtl/axi_master_write.sv
// Single-outstanding AXI write initiator: registered AW, streamed W with wlast, B capture.
module axi_master_write
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 12
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [7:0]          req_len,
    input  logic [2:0]          req_size,
    input  logic [1:0]          req_burst,
    input  logic [ID_W-1:0]     req_id,

    input  logic                wd_valid,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                wd_ready,

    axi_master_write_if.master  m_axi,

    output logic                done_valid,
    output logic [1:0]          done_resp,
    output logic                done_id_err
);

    state_t            state_reg;
    state_t            state_next;
    logic              aw_pend_reg;
    logic              w_done_reg;
    logic [7:0]        beat_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [ID_W-1:0]   id_reg;
    logic              done_valid_reg;
    logic [1:0]        done_resp_reg;
    logic              done_id_err_reg;

    logic in_xfer;
    logic aw_hs;
    logic w_hs;
    logic last_beat;
    logic aw_pend_next;
    logic w_done_next;

    assign in_xfer   = (state_reg == XFER);
    assign last_beat = (beat_cnt_reg == 8'd0);
    assign aw_hs     = m_axi.awvalid && m_axi.awready;
    assign w_hs      = m_axi.wvalid && m_axi.wready;

    assign m_axi.awvalid = in_xfer && aw_pend_reg;
    assign m_axi.awaddr  = addr_reg;
    assign m_axi.awlen   = len_reg;
    assign m_axi.awsize  = size_reg;
    assign m_axi.awburst = burst_reg;
    assign m_axi.awid    = id_reg;

    // Write data is a straight pass-through; only the valid is gated by burst progress.
    assign m_axi.wvalid = in_xfer && wd_valid && !w_done_reg;
    assign m_axi.wdata  = wd_data;
    assign m_axi.wstrb  = wd_strb;
    assign m_axi.wid    = id_reg;
    assign m_axi.wlast  = last_beat;
    assign wd_ready     = m_axi.wready && !w_done_reg && in_xfer;

    assign m_axi.bready = (state_reg == RESP);
    assign req_ready    = (state_reg == IDLE);

    assign done_valid  = done_valid_reg;
    assign done_resp   = done_resp_reg;
    assign done_id_err = done_id_err_reg;

    // Look-ahead flags let XFER leave in the same edge the final handshake lands.
    assign aw_pend_next = aw_pend_reg && !aw_hs;
    assign w_done_next  = w_done_reg || (w_hs && last_beat);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = XFER;
            XFER:    if (!aw_pend_next && w_done_next) state_next = RESP;
            RESP:    if (m_axi.bvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            aw_pend_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            beat_cnt_reg    <= 8'd0;
            addr_reg        <= '0;
            len_reg         <= 8'd0;
            size_reg        <= 3'd0;
            burst_reg       <= 2'd0;
            id_reg          <= '0;
            done_valid_reg  <= 1'b0;
            done_resp_reg   <= 2'd0;
            done_id_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            done_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg     <= req_addr;
                        len_reg      <= req_len;
                        size_reg     <= req_size;
                        burst_reg    <= req_burst;
                        id_reg       <= req_id;
                        beat_cnt_reg <= req_len;
                        aw_pend_reg  <= 1'b1;
                        w_done_reg   <= 1'b0;
                    end
                end
                XFER: begin
                    aw_pend_reg <= aw_pend_next;
                    w_done_reg  <= w_done_next;
                    // Hold at zero on the last beat so the counter never wraps.
                    if (w_hs && !last_beat) begin
                        beat_cnt_reg <= beat_cnt_reg - 8'd1;
                    end
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        done_valid_reg  <= 1'b1;
                        done_resp_reg   <= m_axi.bresp;
                        done_id_err_reg <= (m_axi.bid != id_reg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_write.sv
// Randomized self-checking bench for axi_master_write acting as local source and AXI target.
module tb_axi_master_write;
    import axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 12;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic [2:0]    req_size;
    logic [1:0]    req_burst;
    logic [IW-1:0] req_id;
    logic          wd_valid;
    logic [DW-1:0] wd_data;
    logic [SW-1:0] wd_strb;
    logic          wd_ready;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic          done_id_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_master_write_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

    axi_master_write #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_size    (req_size),
        .req_burst   (req_burst),
        .req_id      (req_id),
        .wd_valid    (wd_valid),
        .wd_data     (wd_data),
        .wd_strb     (wd_strb),
        .wd_ready    (wd_ready),
        .m_axi       (bus),
        .done_valid  (done_valid),
        .done_resp   (done_resp),
        .done_id_err (done_id_err)
    );

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_addr    = '0;
        req_len     = 8'd0;
        req_size    = 3'd0;
        req_burst   = 2'd0;
        req_id      = '0;
        wd_valid    = 1'b0;
        wd_data     = '0;
        wd_strb     = '0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'd0;
        bus.bid     = '0;
    endtask

    // One complete transaction; returns during the done_valid cycle (before its rising edge).
    // wr_mode: 0 wready high, 1 toggling 1,0,..., 2 random. wdv_mode: 0 wd_valid high, 1 random.
    task automatic do_xfer(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [IW-1:0] id, input int aw_delay,
                           input int wr_mode, input int wdv_mode, input int b_early, input int b_delay,
                           input logic [1:0] bresp, input logic bid_err, input int hold, input int exp_lat);
        logic [DW-1:0] bd [256];
        logic [SW-1:0] bs [256];
        int nbeats;
        int beats;
        int aw_cyc;
        int wl_cyc;
        int rs_cyc;
        int cyc;
        int dut_beats;
        int dut_lasts;
        logic ev_aw;
        logic ev_w;
        logic ev_b;
        logic bv;
        logic finished;

        nbeats = int'(len) + 1;
        for (int i = 0; i < nbeats; i++) begin
            bd[i] = $urandom;
            bs[i] = SW'($urandom);
        end
        beats = 0; aw_cyc = -1; wl_cyc = -1; rs_cyc = -1;
        dut_beats = 0; dut_lasts = 0; finished = 1'b0;

        req_valid = 1'b1; req_addr = addr; req_len = len; req_size = size;
        req_burst = burst; req_id = id;
        wd_valid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_accept: req_ready=%0b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = (hold != 0);

        cyc = 0;
        while (cyc < 3000 && !finished) begin
            bus.awready = (cyc >= aw_delay);
            case (wr_mode)
                0:       bus.wready = 1'b1;
                1:       bus.wready = (cyc % 2 == 0);
                default: bus.wready = 1'($urandom);
            endcase
            wd_valid = (wdv_mode == 0) ? 1'b1 : 1'($urandom);
            wd_data  = (beats < nbeats) ? bd[beats] : DW'($urandom);
            wd_strb  = (beats < nbeats) ? bs[beats] : SW'($urandom);
            if (rs_cyc >= 0)
                bv = 1'b0;
            else if (b_early != 0)
                bv = 1'b1;
            else
                bv = (aw_cyc >= 0 && wl_cyc >= 0 && cyc > aw_cyc + b_delay && cyc > wl_cyc + b_delay);
            bus.bvalid = bv;
            bus.bresp  = bresp;
            bus.bid    = bid_err ? id + IW'(1) : id;
            #1;
            if (bus.wvalid === 1'b1 && bus.wready === 1'b1) begin
                dut_beats++;
                if (bus.wlast === 1'b1) dut_lasts++;
            end
            if (rs_cyc >= 0) begin
                vectors++;
                if (done_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL done_pulse: done_valid=%0b want 1", done_valid);
                end
                vectors++;
                if (done_resp !== bresp) begin
                    miscompares++;
                    $display("FAIL done_resp: got %0d want %0d", done_resp, bresp);
                end
                vectors++;
                if (done_id_err !== bid_err) begin
                    miscompares++;
                    $display("FAIL done_id_err: got %0b want %0b", done_id_err, bid_err);
                end
                vectors++;
                if (req_ready !== 1'b1 || bus.bready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_idle: req_ready=%0b bready=%0b want 1/0", req_ready, bus.bready);
                end
                if (exp_lat >= 0) begin
                    vectors++;
                    if (cyc + 1 != exp_lat) begin
                        miscompares++;
                        $display("FAIL latency: got %0d want %0d", cyc + 1, exp_lat);
                    end
                end
                finished = 1'b1;
            end else begin
                ev_aw = (aw_cyc < 0);
                ev_w  = wd_valid && (beats < nbeats);
                ev_b  = (aw_cyc >= 0 && wl_cyc >= 0 && cyc > aw_cyc && cyc > wl_cyc);
                vectors++;
                if (bus.awvalid !== ev_aw) begin
                    miscompares++;
                    $display("FAIL awvalid: cyc %0d got %0b want %0b", cyc, bus.awvalid, ev_aw);
                end
                if (ev_aw) begin
                    vectors++;
                    if ({bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid} !== {addr, len, size, burst, id}) begin
                        miscompares++;
                        $display("FAIL aw_fields: got %0h/%0d/%0d/%0d/%0h want %0h/%0d/%0d/%0d/%0h",
                                 bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid,
                                 addr, len, size, burst, id);
                    end
                end
                vectors++;
                if (bus.wvalid !== ev_w) begin
                    miscompares++;
                    $display("FAIL wvalid: cyc %0d got %0b want %0b", cyc, bus.wvalid, ev_w);
                end
                vectors++;
                if (wd_ready !== (bus.wready && beats < nbeats)) begin
                    miscompares++;
                    $display("FAIL wd_ready: cyc %0d got %0b want %0b", cyc, wd_ready, bus.wready && beats < nbeats);
                end
                if (ev_w) begin
                    vectors++;
                    if ({bus.wdata, bus.wstrb, bus.wid, bus.wlast} !== {bd[beats], bs[beats], id, beats == nbeats - 1}) begin
                        miscompares++;
                        $display("FAIL w_beat%0d: got %0h/%0h/%0h/%0b want %0h/%0h/%0h/%0b", beats,
                                 bus.wdata, bus.wstrb, bus.wid, bus.wlast,
                                 bd[beats], bs[beats], id, beats == nbeats - 1);
                    end
                end
                vectors++;
                if (bus.bready !== ev_b) begin
                    miscompares++;
                    $display("FAIL bready: cyc %0d got %0b want %0b", cyc, bus.bready, ev_b);
                end
                vectors++;
                if (done_valid !== 1'b0 || req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy: cyc %0d done_valid=%0b req_ready=%0b want 0/0", cyc, done_valid, req_ready);
                end
                if (ev_aw && bus.awready) aw_cyc = cyc;
                if (ev_w && bus.wready) begin
                    if (beats == nbeats - 1) wl_cyc = cyc;
                    beats++;
                end
                if (ev_b && bv) rs_cyc = cyc;
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) begin
            miscompares++;
            $display("FAIL timeout: no done_valid after %0d cycles", cyc);
        end
        vectors++;
        if (dut_beats != nbeats || dut_lasts != 1) begin
            miscompares++;
            $display("FAIL beat_count: beats=%0d lasts=%0d want %0d/1", dut_beats, dut_lasts, nbeats);
        end
        $display("xfer id=%03h addr=%08h len=%0d burst=%0d bresp=%0d id_err=%0b done_cycle=%0d",
                 id, addr, len, burst, bresp, bid_err, cyc + 1);
    endtask

    task automatic test_reset();
        idle_inputs();
        wd_valid = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.awvalid, bus.wvalid, bus.bready, done_valid, done_id_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: aw/w/b/done/iderr=%0b%0b%0b%0b%0b want 00000",
                     bus.awvalid, bus.wvalid, bus.bready, done_valid, done_id_err);
        end
        vectors++;
        if ({bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid, done_resp} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields: awaddr=%0h awlen=%0d awid=%0h done_resp=%0d want 0",
                     bus.awaddr, bus.awlen, bus.awid, done_resp);
        end
        vectors++;
        if (req_ready !== 1'b1 || bus.wlast !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: req_ready=%0b wlast=%0b want 1/1", req_ready, bus.wlast);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_beat();
        do_xfer(32'h1000, 8'd0, 3'd2, BURST_INCR, 12'h005, 0, 0, 0, 0, 0, RESP_OKAY, 1'b0, 0, 3);
    endtask

    task automatic test_wready_toggle();
        do_xfer(32'h2000, 8'd3, 3'd2, BURST_INCR, 12'h011, 0, 1, 0, 0, 0, RESP_OKAY, 1'b0, 0, -1);
    endtask

    task automatic test_aw_delay();
        do_xfer(32'h3000, 8'd1, 3'd2, BURST_INCR, 12'h022, 5, 0, 0, 0, 0, RESP_EXOKAY, 1'b0, 0, -1);
    endtask

    task automatic test_bid_error();
        do_xfer(32'h4000, 8'd2, 3'd2, BURST_INCR, 12'h005, 2, 0, 0, 1, 0, RESP_SLVERR, 1'b1, 0, -1);
    endtask

    task automatic test_len_max();
        do_xfer(32'h5000, 8'd255, 3'd2, BURST_INCR, 12'h0ff, 0, 0, 0, 0, 1, RESP_OKAY, 1'b0, 0, -1);
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 1'b1; req_addr = 32'h6000; req_len = 8'd3; req_size = 3'd2;
        req_burst = BURST_INCR; req_id = 12'h033;
        @(negedge clk);
        req_valid = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b1; wd_valid = 1'b1; wd_data = DW'($urandom);
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: awvalid=%0b wvalid=%0b want 1/1", bus.awvalid, bus.wvalid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.awvalid, bus.wvalid, bus.bready, done_valid, req_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL mid_reset: aw/w/b/done/rdy=%0b%0b%0b%0b%0b want 00001",
                     bus.awvalid, bus.wvalid, bus.bready, done_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        do_xfer(32'h6100, 8'd0, 3'd2, BURST_INCR, 12'h034, 0, 0, 0, 0, 0, RESP_OKAY, 1'b0, 0, 3);
    endtask

    task automatic test_back_to_back();
        do_xfer(32'h7000, 8'd2, 3'd2, BURST_INCR, 12'h040, 1, 2, 0, 0, 0, RESP_OKAY, 1'b0, 1, -1);
        do_xfer(32'h7100, 8'd1, 3'd2, BURST_WRAP, 12'h041, 0, 0, 0, 0, 0, RESP_DECERR, 1'b0, 1, -1);
        do_xfer(32'h7200, 8'd0, 3'd2, BURST_FIXED, 12'h042, 0, 0, 0, 0, 0, RESP_OKAY, 1'b0, 0, 3);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            do_xfer($urandom, 8'($urandom_range(0, 15)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    IW'($urandom), $urandom_range(0, 6), 2, $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 3), 2'($urandom), 1'($urandom), $urandom_range(0, 1), -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_wready_toggle();
        test_aw_delay();
        test_bid_error();
        test_len_max();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (done_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_drop: done_valid=%0b want 0", done_valid);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
